// File: rtl/m_csr_trap_unit.sv
// m_csr_trap_unit
//   Execute-side CSR file, privilege tracking and trap/xRET/WFI sequencing.
//   Consumes decoded csr_ops/sys_ops and drives redirect/stall back to the
//   front end so fetch and decode always see the current priv_mode and target.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_RUN    | normal execution, instructions evaluated when instr_valid
//   ST_WFI    | parked after WFI, stall held until mie.MEIE & irq_ext
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   instr_valid     instruction present this cycle
//   pc              PC of that instruction
//   csr_addr        CSR address
//   csr_wdata       write operand (rs1 or zimm)
//   csr_ops         00 none, 01 write, 10 set, 11 clear
//   sys_ops         001 ECALL, 010 EBREAK, 011 MRET, 100 SRET, 101 WFI
//   exc_req/code    exception raised upstream and its cause
//   irq_ext         level machine external interrupt
//   csr_rdata       pre-update CSR value (0 if unimplemented or in reset)
//   priv_mode       00 U, 01 S, 11 M
//   redirect/_pc    flush and fetch target
//   stall           pipeline hold while waiting for interrupt
module m_csr_trap_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MISA_VAL    = 32'h4014_1101
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] pc,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic [1:0]  csr_ops,
    input  logic [2:0]  sys_ops,
    input  logic        exc_req,
    input  logic [3:0]  exc_code,
    input  logic        irq_ext,
    output logic [31:0] csr_rdata,
    output logic [1:0]  priv_mode,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        stall
);

    typedef enum logic {ST_RUN, ST_WFI} state_t;

    localparam logic [1:0]  PRIV_U    = 2'b00;
    localparam logic [1:0]  PRIV_M    = 2'b11;
    localparam logic [2:0]  SYS_ECALL = 3'b001;
    localparam logic [2:0]  SYS_EBRK  = 3'b010;
    localparam logic [2:0]  SYS_MRET  = 3'b011;
    localparam logic [2:0]  SYS_SRET  = 3'b100;
    localparam logic [2:0]  SYS_WFI   = 3'b101;
    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
    localparam logic [31:0] CAUSE_ILL = 32'd2;
    localparam logic [31:0] CAUSE_BRK = 32'd3;
    localparam logic [31:0] ALIGN4    = 32'hFFFF_FFFC;

    state_t      state_q, state_d;
    logic [1:0]  priv_q;
    logic        st_sie, st_mie, st_spie, st_mpie, st_spp;
    logic [1:0]  st_mpp;
    logic        meie_q;
    logic [31:0] mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic [31:0] stvec_q, sscratch_q, sepc_q, scause_q;
    logic [31:0] wfi_pc_q;

    logic [31:0] mstatus_rd, sstatus_rd, rd_val, csr_wval;
    logic        csr_impl, csr_wr_try, illegal, irq_pend;
    logic        trap, do_mret, do_sret, do_csr, enter_wfi;
    logic [31:0] trap_cause, trap_epc;

    assign priv_mode = priv_q;

    always_comb begin
        mstatus_rd        = '0;
        mstatus_rd[1]     = st_sie;
        mstatus_rd[3]     = st_mie;
        mstatus_rd[5]     = st_spie;
        mstatus_rd[7]     = st_mpie;
        mstatus_rd[8]     = st_spp;
        mstatus_rd[12:11] = st_mpp;
        sstatus_rd        = '0;
        sstatus_rd[1]     = st_sie;
        sstatus_rd[5]     = st_spie;
        sstatus_rd[8]     = st_spp;
    end

    always_comb begin
        rd_val   = '0;
        csr_impl = 1'b1;
        case (csr_addr)
            12'h300: rd_val = mstatus_rd;
            12'h301: rd_val = MISA_VAL;
            12'h304: rd_val = {20'd0, meie_q, 11'd0};
            12'h305: rd_val = mtvec_q;
            12'h340: rd_val = mscratch_q;
            12'h341: rd_val = mepc_q;
            12'h342: rd_val = mcause_q;
            12'h344: rd_val = {20'd0, irq_ext, 11'd0};
            12'h100: rd_val = sstatus_rd;
            12'h105: rd_val = stvec_q;
            12'h140: rd_val = sscratch_q;
            12'h141: rd_val = sepc_q;
            12'h142: rd_val = scause_q;
            default: csr_impl = 1'b0;
        endcase
    end

    // Misa is a constant, so the mux is masked to keep reset output at zero.
    assign csr_rdata = rst_n ? rd_val : '0;

    always_comb begin
        case (csr_ops)
            2'b01:   csr_wval = csr_wdata;
            2'b10:   csr_wval = rd_val | csr_wdata;
            default: csr_wval = rd_val & ~csr_wdata;
        endcase
    end

    // Set/clear with a zero operand is a pure read and must not trip the
    // read-only-address check.
    assign csr_wr_try = (csr_ops == 2'b01) || ((csr_ops != 2'b00) && (csr_wdata != '0));
    assign irq_pend   = meie_q & irq_ext;

    assign illegal = ((csr_ops != 2'b00) && (!csr_impl || (csr_addr[9:8] > priv_q)))
                   || (csr_wr_try && (csr_addr[11:10] == 2'b11))
                   || ((sys_ops == SYS_MRET) && (priv_q != PRIV_M))
                   || ((sys_ops == SYS_SRET) && (priv_q == PRIV_U));

    always_comb begin
        state_d     = state_q;
        trap        = 1'b0;
        trap_cause  = '0;
        trap_epc    = pc;
        do_mret     = 1'b0;
        do_sret     = 1'b0;
        do_csr      = 1'b0;
        enter_wfi   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = mtvec_q;
        stall       = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (rst_n && instr_valid) begin
                    if (st_mie && irq_pend) begin
                        trap       = 1'b1;
                        trap_cause = CAUSE_MEI;
                    end else if (exc_req) begin
                        trap       = 1'b1;
                        trap_cause = {28'd0, exc_code};
                    end else if (illegal) begin
                        trap       = 1'b1;
                        trap_cause = CAUSE_ILL;
                    end else if (sys_ops == SYS_ECALL) begin
                        trap       = 1'b1;
                        trap_cause = {28'd0, 2'b10, priv_q};
                    end else if (sys_ops == SYS_EBRK) begin
                        trap       = 1'b1;
                        trap_cause = CAUSE_BRK;
                    end else if (sys_ops == SYS_MRET) begin
                        do_mret = 1'b1;
                    end else if (sys_ops == SYS_SRET) begin
                        do_sret = 1'b1;
                    end else if (sys_ops == SYS_WFI) begin
                        enter_wfi = 1'b1;
                        state_d   = ST_WFI;
                    end else begin
                        do_csr = csr_wr_try;
                    end
                end
            end
            ST_WFI: begin
                if (irq_pend) begin
                    state_d = ST_RUN;
                    // Wake with MIE clear just resumes at pc+4 without a trap.
                    if (st_mie) begin
                        trap       = 1'b1;
                        trap_cause = CAUSE_MEI;
                        trap_epc   = wfi_pc_q + 32'd4;
                    end
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
        if (trap) begin
            redirect = 1'b1;
        end else if (do_mret) begin
            redirect    = 1'b1;
            redirect_pc = mepc_q;
        end else if (do_sret) begin
            redirect    = 1'b1;
            redirect_pc = sepc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            priv_q     <= PRIV_M;
            st_sie     <= 1'b0;
            st_mie     <= 1'b0;
            st_spie    <= 1'b0;
            st_mpie    <= 1'b0;
            st_spp     <= 1'b0;
            st_mpp     <= 2'b00;
            meie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            stvec_q    <= '0;
            sscratch_q <= '0;
            sepc_q     <= '0;
            scause_q   <= '0;
            wfi_pc_q   <= '0;
        end else begin
            state_q <= state_d;
            if (enter_wfi) begin
                wfi_pc_q <= pc;
            end
            if (trap) begin
                mepc_q   <= trap_epc & ALIGN4;
                mcause_q <= trap_cause;
                st_mpie  <= st_mie;
                st_mie   <= 1'b0;
                st_mpp   <= priv_q;
                priv_q   <= PRIV_M;
            end else if (do_mret) begin
                priv_q  <= st_mpp;
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
                st_mpp  <= PRIV_U;
            end else if (do_sret) begin
                priv_q  <= {1'b0, st_spp};
                st_sie  <= st_spie;
                st_spie <= 1'b1;
                st_spp  <= 1'b0;
            end else if (do_csr) begin
                case (csr_addr)
                    12'h300: begin
                        st_sie  <= csr_wval[1];
                        st_mie  <= csr_wval[3];
                        st_spie <= csr_wval[5];
                        st_mpie <= csr_wval[7];
                        st_spp  <= csr_wval[8];
                        st_mpp  <= csr_wval[12:11];
                    end
                    12'h100: begin
                        st_sie  <= csr_wval[1];
                        st_spie <= csr_wval[5];
                        st_spp  <= csr_wval[8];
                    end
                    12'h304: meie_q     <= csr_wval[11];
                    12'h305: mtvec_q    <= csr_wval & ALIGN4;
                    12'h340: mscratch_q <= csr_wval;
                    12'h341: mepc_q     <= csr_wval & ALIGN4;
                    12'h342: mcause_q   <= csr_wval;
                    12'h105: stvec_q    <= csr_wval;
                    12'h140: sscratch_q <= csr_wval;
                    12'h141: sepc_q     <= csr_wval;
                    12'h142: scause_q   <= csr_wval;
                    default: ;
                endcase
            end
        end
    end

endmodule
